multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 264 ++++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for a multicycle processor whose memory bus is
// MEMW bits wide. A 32-bit instruction or data word therefore takes
// BEATS = 32/MEMW bus transfers.
//
// Ports
//   clk, reset             single rising-edge clock; asynchronous active-high reset
//   instr, zero, mem_ready instruction register, ALU zero flag, memory handshake
//   memread, memwrite      memory request strobes
//   iord                   address select (0 = PC, 1 = ALU)
//   beat                   beat index, added to the address by the datapath
//   irwrite, mdrwrite      one-hot lane enables for the IR and MDR
//   regwrite, regdst, memtoreg         register file controls
//   pcen, pcsrc                        PC controls
//   alusrca, alusrcb, alucont          ALU controls
//   state, instr_done, illegal_op      debug state and status pulses
//
// State table
//   state    | meaning
//   FETCH    | read instruction beats into the IR; PC += MEMW/8 per beat
//   DECODE   | compute the branch target; dispatch on the opcode
//   MEMADR   | compute the load/store address
//   MEMRD    | read data beats into the MDR (1 beat for LB, BEATS for LW)
//   MEMWB    | write loaded data to the register file
//   MEMWR    | write data beats (1 beat for SB, BEATS for SW)
//   RTYPEEX  | R-type ALU operation selected by funct
//   RTYPEWB  | write the R-type result to rd
//   BEQEX    | compare; take the branch when zero is set
//   ADDIEX   | add immediate
//   ADDIWB   | write the ADDI result to rt
//   JEX      | jump
//   ILLEGAL  | unknown opcode: one-cycle flag, nothing written

module multicycle_ctrl #(
    parameter int MEMW = 8,
    localparam int BEATS = 32 / MEMW,
    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             memread,
    output logic             memwrite,
    output logic             iord,
    output logic [BW-1:0]    beat,
    output logic [BEATS-1:0] irwrite,
    output logic [BEATS-1:0] mdrwrite,
    output logic             regwrite,
    output logic             regdst,
    output logic             memtoreg,
    output logic             pcen,
    output logic [1:0]       pcsrc,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [2:0]       alucont,
    output logic [3:0]       state,
    output logic             instr_done,
    output logic             illegal_op
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11,
        S_ILLEGAL = 4'd12
    } state_t;

    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    state_t          state_q, state_d;
    logic [BW-1:0]   beat_q, beat_d;

    logic [5:0]      op;
    logic [5:0]      funct;
    logic            is_store;
    logic            mem_last;
    logic [BEATS-1:0] lane;
    logic            unused_instr;

    assign op    = instr[31:26];
    assign funct = instr[5:0];
    assign unused_instr = ^instr[25:6];

    // Opcode bit 29 separates stores (101xxx) from loads (100xxx); bit 26
    // separates word accesses (xxxx11) from byte accesses (xxxx00).
    assign is_store = op[3];
    // Byte accesses are a single beat at index 0; word accesses run all beats.
    assign mem_last = op[0] ? (beat_q == LAST_BEAT) : 1'b1;
    assign lane     = BEATS'(1) << beat_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        memread    = 1'b0;
        memwrite   = 1'b0;
        iord       = 1'b0;
        beat       = '0;
        irwrite    = '0;
        mdrwrite   = '0;
        regwrite   = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        pcen       = 1'b0;
        pcsrc      = 2'b00;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        alucont    = 3'b000;
        state      = 4'd0;
        instr_done = 1'b0;
        illegal_op = 1'b0;

        // Reset forces every output low combinationally so a mid-instruction
        // reset drops all strobes without waiting for a clock edge.
        if (!reset) begin
            state = state_q;
            beat  = beat_q;
            case (state_q)
                S_FETCH: begin
                    memread = 1'b1;
                    alusrcb = 2'b01;
                    alucont = 3'b010;
                    if (mem_ready) begin
                        irwrite = lane;
                        pcen    = 1'b1;
                        if (beat_q == LAST_BEAT) begin
                            beat_d  = '0;
                            state_d = S_DECODE;
                        end else begin
                            beat_d = beat_q + BW'(1);
                        end
                    end
                end
                S_DECODE: begin
                    alusrcb = 2'b11;
                    alucont = 3'b010;
                    beat_d  = '0;
                    case (op)
                        6'b100000, 6'b100011,
                        6'b101000, 6'b101011: state_d = S_MEMADR;
                        6'b000000:            state_d = S_RTYPEEX;
                        6'b000100:            state_d = S_BEQEX;
                        6'b001000:            state_d = S_ADDIEX;
                        6'b000010:            state_d = S_JEX;
                        default:              state_d = S_ILLEGAL;
                    endcase
                end
                S_MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                    alucont = 3'b010;
                    state_d = is_store ? S_MEMWR : S_MEMRD;
                end
                S_MEMRD: begin
                    memread = 1'b1;
                    iord    = 1'b1;
                    if (mem_ready) begin
                        mdrwrite = lane;
                        if (mem_last) begin
                            beat_d  = '0;
                            state_d = S_MEMWB;
                        end else begin
                            beat_d = beat_q + BW'(1);
                        end
                    end
                end
                S_MEMWB: begin
                    regwrite   = 1'b1;
                    memtoreg   = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                S_MEMWR: begin
                    memwrite = 1'b1;
                    iord     = 1'b1;
                    if (mem_ready) begin
                        if (mem_last) begin
                            instr_done = 1'b1;
                            beat_d     = '0;
                            state_d    = S_FETCH;
                        end else begin
                            beat_d = beat_q + BW'(1);
                        end
                    end
                end
                S_RTYPEEX: begin
                    alusrca = 1'b1;
                    case (funct)
                        6'b100000: alucont = 3'b010;
                        6'b100010: alucont = 3'b110;
                        6'b100100: alucont = 3'b000;
                        6'b100101: alucont = 3'b001;
                        6'b101010: alucont = 3'b111;
                        default:   alucont = 3'b010;
                    endcase
                    state_d = S_RTYPEWB;
                end
                S_RTYPEWB: begin
                    regwrite   = 1'b1;
                    regdst     = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                S_BEQEX: begin
                    alusrca    = 1'b1;
                    alucont    = 3'b110;
                    pcsrc      = 2'b01;
                    pcen       = zero;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                S_ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                    alucont = 3'b010;
                    state_d = S_ADDIWB;
                end
                S_ADDIWB: begin
                    regwrite   = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                S_JEX: begin
                    pcsrc      = 2'b10;
                    pcen       = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                S_ILLEGAL: begin
                    illegal_op = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                default: begin
                    // Encodings 13-15: outputs stay at their zero defaults.
                    state = 4'd0;
                    beat  = '0;
                    state_d = S_FETCH;
                    beat_d  = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr = 32'h0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;

    logic       m_mr, m_mw, m_iord, m_rw, m_rd, m_m2r, m_pcen, m_asa, m_done, m_ill;
    logic [1:0] m_beat, m_pcsrc, m_asb;
    logic [3:0] m_irw, m_mdrw, m_st;
    logic [2:0] m_ac;

    logic       w_mr, w_mw, w_iord, w_rw, w_rd, w_m2r, w_pcen, w_asa, w_done, w_ill;
    logic [0:0] w_beat, w_irw, w_mdrw;
    logic [1:0] w_pcsrc, w_asb;
    logic [3:0] w_st;
    logic [2:0] w_ac;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEMW(8)) dut8 (
        .clk(clk), .reset(reset), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .memread(m_mr), .memwrite(m_mw), .iord(m_iord), .beat(m_beat),
        .irwrite(m_irw), .mdrwrite(m_mdrw), .regwrite(m_rw), .regdst(m_rd),
        .memtoreg(m_m2r), .pcen(m_pcen), .pcsrc(m_pcsrc), .alusrca(m_asa),
        .alusrcb(m_asb), .alucont(m_ac), .state(m_st), .instr_done(m_done),
        .illegal_op(m_ill)
    );

    multicycle_ctrl #(.MEMW(32)) dut32 (
        .clk(clk), .reset(reset), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .memread(w_mr), .memwrite(w_mw), .iord(w_iord), .beat(w_beat),
        .irwrite(w_irw), .mdrwrite(w_mdrw), .regwrite(w_rw), .regdst(w_rd),
        .memtoreg(w_m2r), .pcen(w_pcen), .pcsrc(w_pcsrc), .alusrca(w_asa),
        .alusrcb(w_asb), .alucont(w_ac), .state(w_st), .instr_done(w_done),
        .illegal_op(w_ill)
    );

    typedef struct packed {
        logic [3:0] st;
        logic [1:0] bt;
        logic       mr, mw, iord;
        logic [3:0] irw, mdrw;
        logic       rw, rd, m2r, pcen;
        logic [1:0] pcsrc;
        logic       asa;
        logic [1:0] asb;
        logic [2:0] ac;
        logic       done, ill;
    } exp_t;

    typedef struct {
        logic        rdy;
        logic [31:0] ins;
        logic        z;
        exp_t        e;
    } item_t;

    item_t       sb[$];
    logic [31:0] cur_instr = 32'h0;
    logic        cur_zero = 1'b0;

    function automatic exp_t obs8();
        exp_t o;
        o.st = m_st; o.bt = m_beat; o.mr = m_mr; o.mw = m_mw; o.iord = m_iord;
        o.irw = m_irw; o.mdrw = m_mdrw; o.rw = m_rw; o.rd = m_rd; o.m2r = m_m2r;
        o.pcen = m_pcen; o.pcsrc = m_pcsrc; o.asa = m_asa; o.asb = m_asb;
        o.ac = m_ac; o.done = m_done; o.ill = m_ill;
        return o;
    endfunction

    function automatic exp_t obs32();
        exp_t o;
        o.st = w_st; o.bt = {1'b0, w_beat}; o.mr = w_mr; o.mw = w_mw; o.iord = w_iord;
        o.irw = {3'b000, w_irw}; o.mdrw = {3'b000, w_mdrw}; o.rw = w_rw; o.rd = w_rd;
        o.m2r = w_m2r; o.pcen = w_pcen; o.pcsrc = w_pcsrc; o.asa = w_asa;
        o.asb = w_asb; o.ac = w_ac; o.done = w_done; o.ill = w_ill;
        return o;
    endfunction

    // Expected output vectors, one per state, written from the state descriptions.
    function automatic exp_t e_fetch(int b, logic rdy);
        exp_t e = '0;
        e.st = 4'd0; e.bt = b[1:0]; e.mr = 1'b1; e.asb = 2'b01; e.ac = 3'b010;
        if (rdy) begin e.irw = 4'b0001 << b; e.pcen = 1'b1; end
        return e;
    endfunction
    function automatic exp_t e_decode();
        exp_t e = '0;
        e.st = 4'd1; e.asb = 2'b11; e.ac = 3'b010;
        return e;
    endfunction
    function automatic exp_t e_memadr();
        exp_t e = '0;
        e.st = 4'd2; e.asa = 1'b1; e.asb = 2'b10; e.ac = 3'b010;
        return e;
    endfunction
    function automatic exp_t e_memrd(int b, logic rdy);
        exp_t e = '0;
        e.st = 4'd3; e.bt = b[1:0]; e.mr = 1'b1; e.iord = 1'b1;
        if (rdy) e.mdrw = 4'b0001 << b;
        return e;
    endfunction
    function automatic exp_t e_memwb();
        exp_t e = '0;
        e.st = 4'd4; e.rw = 1'b1; e.m2r = 1'b1; e.done = 1'b1;
        return e;
    endfunction
    function automatic exp_t e_memwr(int b, logic rdy, logic last);
        exp_t e = '0;
        e.st = 4'd5; e.bt = b[1:0]; e.mw = 1'b1; e.iord = 1'b1; e.done = rdy & last;
        return e;
    endfunction
    function automatic exp_t e_rtex(logic [2:0] ac);
        exp_t e = '0;
        e.st = 4'd6; e.asa = 1'b1; e.ac = ac;
        return e;
    endfunction
    function automatic exp_t e_rtwb();
        exp_t e = '0;
        e.st = 4'd7; e.rw = 1'b1; e.rd = 1'b1; e.done = 1'b1;
        return e;
    endfunction
    function automatic exp_t e_beq(logic z);
        exp_t e = '0;
        e.st = 4'd8; e.asa = 1'b1; e.ac = 3'b110; e.pcsrc = 2'b01; e.pcen = z; e.done = 1'b1;
        return e;
    endfunction
    function automatic exp_t e_addiex();
        exp_t e = '0;
        e.st = 4'd9; e.asa = 1'b1; e.asb = 2'b10; e.ac = 3'b010;
        return e;
    endfunction
    function automatic exp_t e_addiwb();
        exp_t e = '0;
        e.st = 4'd10; e.rw = 1'b1; e.done = 1'b1;
        return e;
    endfunction
    function automatic exp_t e_jex();
        exp_t e = '0;
        e.st = 4'd11; e.pcsrc = 2'b10; e.pcen = 1'b1; e.done = 1'b1;
        return e;
    endfunction
    function automatic exp_t e_ill();
        exp_t e = '0;
        e.st = 4'd12; e.ill = 1'b1; e.done = 1'b1;
        return e;
    endfunction

    task automatic push(input logic rdy, input exp_t e);
        item_t it;
        it.rdy = rdy; it.ins = cur_instr; it.z = cur_zero; it.e = e;
        sb.push_back(it);
    endtask

    task automatic push_fetch();
        for (int b = 0; b < 4; b++) push(1'b1, e_fetch(b, 1'b1));
    endtask

    // Every test starts just after a falling edge; each scoreboard entry
    // covers one clock cycle.
    task automatic test_reset();
        exp_t o;
        instr = 32'h2008_0005;
        mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            o = obs8(); total++;
            if (o !== exp_t'(0)) begin bad++; $display("FAIL reset8 cyc%0d: got %h want %h", i, o, exp_t'(0)); end
            o = obs32(); total++;
            if (o !== exp_t'(0)) begin bad++; $display("FAIL reset32 cyc%0d: got %h want %h", i, o, exp_t'(0)); end
        end
        reset = 1'b0;
    endtask

    task automatic test_addi();
        item_t it; exp_t o; int n = 0;
        cur_instr = 32'h2008_0005; cur_zero = 1'b0;
        push_fetch(); push(1'b1, e_decode()); push(1'b1, e_addiex()); push(1'b1, e_addiwb());
        while (sb.size() != 0) begin
            it = sb.pop_front();
            instr = it.ins; zero = it.z; mem_ready = it.rdy; #1;
            o = obs8(); total++;
            if (o !== it.e) begin bad++; $display("FAIL addi cyc%0d: got %h want %h", n, o, it.e); end
            @(negedge clk); n++;
        end
    endtask

    task automatic test_rtype();
        item_t it; exp_t o; int n = 0;
        logic [5:0] fn [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
        logic [2:0] ac [6] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010};
        for (int k = 0; k < 6; k++) begin
            cur_instr = {26'h0, fn[k]};
            push_fetch(); push(1'b1, e_decode()); push(1'b1, e_rtex(ac[k])); push(1'b1, e_rtwb());
        end
        while (sb.size() != 0) begin
            it = sb.pop_front();
            instr = it.ins; zero = it.z; mem_ready = it.rdy; #1;
            o = obs8(); total++;
            if (o !== it.e) begin bad++; $display("FAIL rtype cyc%0d: got %h want %h", n, o, it.e); end
            @(negedge clk); n++;
        end
    endtask

    task automatic test_mem();
        item_t it; exp_t o; int n = 0;
        cur_instr = 32'h8C00_0000;
        push_fetch(); push(1'b1, e_decode()); push(1'b1, e_memadr());
        for (int b = 0; b < 4; b++) push(1'b1, e_memrd(b, 1'b1));
        push(1'b1, e_memwb());
        cur_instr = 32'h8000_0000;
        push_fetch(); push(1'b1, e_decode()); push(1'b1, e_memadr());
        push(1'b1, e_memrd(0, 1'b1)); push(1'b1, e_memwb());
        cur_instr = 32'hAC00_0000;
        push_fetch(); push(1'b1, e_decode()); push(1'b1, e_memadr());
        for (int b = 0; b < 4; b++) push(1'b1, e_memwr(b, 1'b1, b == 3));
        cur_instr = 32'hA000_0000;
        push_fetch(); push(1'b1, e_decode()); push(1'b1, e_memadr());
        push(1'b1, e_memwr(0, 1'b1, 1'b1));
        while (sb.size() != 0) begin
            it = sb.pop_front();
            instr = it.ins; zero = it.z; mem_ready = it.rdy; #1;
            o = obs8(); total++;
            if (o !== it.e) begin bad++; $display("FAIL mem cyc%0d: got %h want %h", n, o, it.e); end
            @(negedge clk); n++;
        end
    endtask

    task automatic test_stall();
        item_t it; exp_t o; int n = 0;
        cur_instr = 32'h2008_0005;
        push(1'b1, e_fetch(0, 1'b1)); push(1'b1, e_fetch(1, 1'b1));
        for (int i = 0; i < 3; i++) push(1'b0, e_fetch(2, 1'b0));
        push(1'b1, e_fetch(2, 1'b1)); push(1'b1, e_fetch(3, 1'b1));
        push(1'b0, e_decode()); push(1'b1, e_addiex()); push(1'b1, e_addiwb());
        cur_instr = 32'h8C00_0000;
        push_fetch(); push(1'b1, e_decode()); push(1'b1, e_memadr());
        push(1'b1, e_memrd(0, 1'b1)); push(1'b1, e_memrd(1, 1'b1));
        push(1'b0, e_memrd(2, 1'b0)); push(1'b0, e_memrd(2, 1'b0));
        push(1'b1, e_memrd(2, 1'b1)); push(1'b1, e_memrd(3, 1'b1)); push(1'b1, e_memwb());
        cur_instr = 32'hAC00_0000;
        push_fetch(); push(1'b1, e_decode()); push(1'b1, e_memadr());
        for (int b = 0; b < 3; b++) push(1'b1, e_memwr(b, 1'b1, 1'b0));
        push(1'b0, e_memwr(3, 1'b0, 1'b1)); push(1'b1, e_memwr(3, 1'b1, 1'b1));
        while (sb.size() != 0) begin
            it = sb.pop_front();
            instr = it.ins; zero = it.z; mem_ready = it.rdy; #1;
            o = obs8(); total++;
            if (o !== it.e) begin bad++; $display("FAIL stall cyc%0d: got %h want %h", n, o, it.e); end
            @(negedge clk); n++;
        end
    endtask

    task automatic test_branch_jump();
        item_t it; exp_t o; int n = 0;
        cur_instr = 32'h1000_0000; cur_zero = 1'b0;
        push_fetch(); push(1'b1, e_decode()); push(1'b1, e_beq(1'b0));
        cur_zero = 1'b1;
        push_fetch(); push(1'b1, e_decode()); push(1'b1, e_beq(1'b1));
        cur_instr = 32'h0800_0000; cur_zero = 1'b0;
        push_fetch(); push(1'b1, e_decode()); push(1'b1, e_jex());
        while (sb.size() != 0) begin
            it = sb.pop_front();
            instr = it.ins; zero = it.z; mem_ready = it.rdy; #1;
            o = obs8(); total++;
            if (o !== it.e) begin bad++; $display("FAIL branch cyc%0d: got %h want %h", n, o, it.e); end
            @(negedge clk); n++;
        end
    endtask

    task automatic test_illegal_reset();
        item_t it; exp_t o; int n = 0;
        cur_instr = 32'hFC00_0000;
        push_fetch(); push(1'b1, e_decode()); push(1'b1, e_ill());
        cur_instr = 32'h8C00_0000;
        push_fetch(); push(1'b1, e_decode()); push(1'b1, e_memadr()); push(1'b1, e_memrd(0, 1'b1));
        while (sb.size() != 0) begin
            it = sb.pop_front();
            instr = it.ins; zero = it.z; mem_ready = it.rdy; #1;
            o = obs8(); total++;
            if (o !== it.e) begin bad++; $display("FAIL illegal cyc%0d: got %h want %h", n, o, it.e); end
            @(negedge clk); n++;
        end
        // Now in MEMRD beat 1: reset must silence everything without a clock edge.
        mem_ready = 1'b1;
        reset = 1'b1; #1;
        o = obs8(); total++;
        if (o !== exp_t'(0)) begin bad++; $display("FAIL midreset_async: got %h want %h", o, exp_t'(0)); end
        @(negedge clk); #1;
        o = obs8(); total++;
        if (o !== exp_t'(0)) begin bad++; $display("FAIL midreset_hold: got %h want %h", o, exp_t'(0)); end
        reset = 1'b0;
        cur_instr = 32'h2008_0005; n = 0;
        push_fetch(); push(1'b1, e_decode()); push(1'b1, e_addiex()); push(1'b1, e_addiwb());
        while (sb.size() != 0) begin
            it = sb.pop_front();
            instr = it.ins; zero = it.z; mem_ready = it.rdy; #1;
            o = obs8(); total++;
            if (o !== it.e) begin bad++; $display("FAIL after_reset cyc%0d: got %h want %h", n, o, it.e); end
            @(negedge clk); n++;
        end
    endtask

    task automatic test_memw32();
        item_t it; exp_t o; int n = 0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cur_instr = 32'hAC00_0000;
        push(1'b1, e_fetch(0, 1'b1)); push(1'b1, e_decode()); push(1'b1, e_memadr());
        push(1'b1, e_memwr(0, 1'b1, 1'b1));
        cur_instr = 32'h8C00_0000;
        push(1'b0, e_fetch(0, 1'b0)); push(1'b1, e_fetch(0, 1'b1)); push(1'b1, e_decode());
        push(1'b1, e_memadr()); push(1'b0, e_memrd(0, 1'b0)); push(1'b1, e_memrd(0, 1'b1));
        push(1'b1, e_memwb());
        while (sb.size() != 0) begin
            it = sb.pop_front();
            instr = it.ins; zero = it.z; mem_ready = it.rdy; #1;
            o = obs32(); total++;
            if (o !== it.e) begin bad++; $display("FAIL memw32 cyc%0d: got %h want %h", n, o, it.e); end
            @(negedge clk); n++;
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_rtype();
        test_mem();
        test_stall();
        test_branch_jump();
        test_illegal_reset();
        test_memw32();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
